// File: rtl/tri_transform_pkg.sv
// Shared types and constants for the triangle transform block: Q16.16 words,
// vertex/triangle/matrix layouts and the accumulator saturation helper.
package tri_transform_pkg;

    localparam int          FRAC_BITS_DEF = 16;
    localparam logic [31:0] FX_ONE        = 32'h0001_0000;
    localparam int          PROD_W        = 64;
    localparam int          ACC_W         = 66;
    localparam int          MAC_STEPS     = 48;

    // Component index 3=x, 2=y, 1=z, 0=w.
    typedef logic [3:0][31:0]       vertex_t;
    typedef vertex_t [2:0]          tri_t;
    typedef logic [3:0][3:0][31:0]  mat_t;

    typedef struct packed {
        logic [31:0] word;
        logic        sat;
    } sat_word_t;

    // Clamp a shifted accumulator value into the signed 32-bit range.
    function automatic sat_word_t saturate(input logic signed [ACC_W-1:0] value);
        sat_word_t r;
        r.sat = !((&value[ACC_W-1:31]) || !(|value[ACC_W-1:31]));
        if (r.sat) begin
            r.word = value[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            r.word = value[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tri_transform_fx_mac.sv
// Two-stage fixed-point MAC: registered 32x32 signed product, then a 66-bit
// accumulate that emits a shifted, saturated word on the last term of a sum.
module fx_mac
    import tri_transform_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clear,
    input  logic        issue,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    input  logic        word_end,
    input  logic [3:0]  tag,
    output logic        done,
    output logic [3:0]  done_tag,
    output logic [31:0] word,
    output logic        word_sat
);

    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_vld_q;
    logic                     prod_end_q;
    logic [3:0]               prod_tag_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    sat_word_t                res;

    always_comb begin
        sum     = acc_q + $signed({{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});
        shifted = sum >>> FRAC_BITS;
        res     = saturate(shifted);
    end

    // NOTE: product/tag payload registers carry no reset; only the valid bit
    // and accumulator need a defined value, which keeps the multiplier path lean.
    always_ff @(posedge clk_in) begin
        if (issue) begin
            prod_q <= $signed(mul_a) * $signed(mul_b);
        end
        prod_end_q <= word_end;
        prod_tag_q <= tag;
    end

    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= issue;
            if (prod_vld_q) begin
                acc_q <= prod_end_q ? '0 : sum;
            end
        end
    end

    assign done     = prod_vld_q && prod_end_q;
    assign done_tag = prod_tag_q;
    assign word     = res.word;
    assign word_sat = res.sat;

endmodule

// File: rtl/tri_transform.sv
// Triangle transform: captures a triangle and a 4x4 matrix, runs 48 serial MACs
// through fx_mac, and holds the transformed triangle until downstream accepts.
module tri_transform
    import tri_transform_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  tri_t  tri_in,
    input  logic  last_in,
    input  logic  valid_in,
    output logic  ready_out,
    input  mat_t  mat_in,
    output tri_t  tri_out,
    output logic  last_out,
    output logic  valid_out,
    input  logic  ready_in,
    output logic  sat_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q;
    logic [5:0]  step_q;
    tri_t        tri_q;
    mat_t        mat_q;
    tri_t        res_q;
    logic        last_q;
    logic        sat_q;

    logic        accept;
    logic        mac_issue;
    logic [1:0]  mac_v;
    logic [1:0]  mac_k;
    logic [1:0]  mac_j;
    logic        mac_done;
    logic [3:0]  mac_done_tag;
    logic [31:0] mac_word;
    logic        mac_sat;

    assign accept = (state_q == ST_IDLE) && valid_in;

    // Step order: vertex 0..2, component 3..0, term 3..0.
    always_comb begin
        mac_issue = 1'b0;
        mac_v     = 2'd0;
        mac_k     = 2'd0;
        mac_j     = 2'd0;
        if (state_q == ST_MAC && step_q < 6'(MAC_STEPS)) begin
            mac_issue = 1'b1;
            mac_v     = step_q[5:4];
            mac_k     = ~step_q[3:2];
            mac_j     = ~step_q[1:0];
        end
    end

    fx_mac #(
        .FRAC_BITS (FRAC_BITS)
    ) u_fx_mac (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (accept),
        .issue    (mac_issue),
        .mul_a    (mat_q[mac_k][mac_j]),
        .mul_b    (tri_q[mac_v][mac_j]),
        .word_end (mac_j == 2'd0),
        .tag      ({mac_v, mac_k}),
        .done     (mac_done),
        .done_tag (mac_done_tag),
        .word     (mac_word),
        .word_sat (mac_sat)
    );

    // Operands are frozen at acceptance so later mat_in/tri_in changes are invisible.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            tri_q <= tri_in;
            mat_q <= mat_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            res_q   <= '0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        state_q <= ST_MAC;
                        step_q  <= '0;
                        last_q  <= last_in;
                        sat_q   <= 1'b0;
                    end
                end
                ST_MAC: begin
                    if (mac_done) begin
                        res_q[mac_done_tag[3:2]][mac_done_tag[1:0]] <= mac_word;
                        sat_q <= sat_q | mac_sat;
                    end
                    // The extra step drains the product register into the last word.
                    if (step_q == 6'(MAC_STEPS)) begin
                        state_q <= ST_HOLD;
                    end else begin
                        step_q <= step_q + 6'd1;
                    end
                end
                ST_HOLD: begin
                    if (ready_in) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_out = (state_q == ST_IDLE);
    assign valid_out = (state_q == ST_HOLD);
    assign tri_out   = res_q;
    assign last_out  = last_q;
    assign sat_out   = sat_q;

endmodule

// File: tb/tb_tri_transform.sv
// Directed bench for tri_transform: table of matrix/triangle vectors with
// hand-computed results, plus stall, back-to-back and mid-MAC reset sequences.
module tb_tri_transform;
    import tri_transform_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    tri_t tri_in;
    logic last_in;
    logic valid_in;
    logic ready_out;
    mat_t mat_in;
    tri_t tri_out;
    logic last_out;
    logic valid_out;
    logic ready_in;
    logic sat_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        mat_t  m;
        tri_t  t;
        logic  last;
        tri_t  exp_t;
        logic  exp_sat;
    } vec_t;

    vec_t vecs[6];

    tri_transform #(.FRAC_BITS(16)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .tri_in    (tri_in),
        .last_in   (last_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .mat_in    (mat_in),
        .tri_out   (tri_out),
        .last_out  (last_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .sat_out   (sat_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic vertex_t mkv(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] z, input logic [31:0] w);
        return {x, y, z, w};
    endfunction

    function automatic tri_t mkt(input vertex_t v0, input vertex_t v1, input vertex_t v2);
        return {v2, v1, v0};
    endfunction

    function automatic mat_t diag(input logic [31:0] d);
        mat_t m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = d;
        return m;
    endfunction

    function automatic mat_t scramble();
        mat_t m;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                m[k][j] = $urandom();
        return m;
    endfunction

    // Accept one triangle, change mat_in mid-MAC, check latency/results, stall, transfer.
    task automatic run_tri(input string name, input mat_t m, input tri_t t, input logic l,
                           input int stall, input tri_t et, input logic esat);
        int w;
        int lat;
        w = 0;
        while (!ready_out && w < 100) begin
            tick();
            w++;
        end
        check({name, " ready"}, 384'(ready_out), 384'(1));
        mat_in   = m;
        tri_in   = t;
        last_in  = l;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tri_in   = '0;
        last_in  = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 20) mat_in = scramble();
            tick();
            if (valid_out) begin
                lat = c;
                break;
            end
        end
        check({name, " latency"}, 384'(lat), 384'(49));
        check({name, " tri_out"}, tri_out, et);
        check({name, " flags"}, {380'd0, sat_out, last_out, ready_out, valid_out},
              {380'd0, esat, l, 1'b0, 1'b1});
        for (int s = 0; s < stall; s++) begin
            valid_in = 1'b1;
            tick();
            check({name, " stall tri_out"}, tri_out, et);
            check({name, " stall flags"}, {380'd0, sat_out, last_out, ready_out, valid_out},
                  {380'd0, esat, l, 1'b0, 1'b1});
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        valid_in = 1'b0;
        check({name, " transfer"}, {382'd0, ready_out, valid_out}, {382'd0, 1'b1, 1'b0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mat_t   mt;
        int     seen;
        vertex_t z4;
        z4 = '0;

        vecs[0].name  = "identity";
        vecs[0].m     = diag(FX_ONE);
        vecs[0].t     = mkt(mkv(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, FX_ONE),
                            mkv(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000),
                            mkv(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF));
        vecs[0].last  = 1'b0;
        vecs[0].exp_t = mkt(mkv(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, FX_ONE),
                            mkv(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000),
                            mkv(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF));
        vecs[0].exp_sat = 1'b0;

        mt = diag(FX_ONE);
        mt[3][0] = 32'h0005_0000;
        vecs[1].name  = "translate";
        vecs[1].m     = mt;
        vecs[1].t     = mkt(mkv(32'h0001_0000, 32'h0, 32'h0, FX_ONE),
                            mkv(32'hFFFE_0000, 32'h0003_0000, 32'h0, FX_ONE),
                            mkv(32'h0, 32'h0, 32'h0007_0000, 32'h0));
        vecs[1].last  = 1'b1;
        vecs[1].exp_t = mkt(mkv(32'h0006_0000, 32'h0, 32'h0, FX_ONE),
                            mkv(32'h0003_0000, 32'h0003_0000, 32'h0, FX_ONE),
                            mkv(32'h0, 32'h0, 32'h0007_0000, 32'h0));
        vecs[1].exp_sat = 1'b0;

        vecs[2].name  = "scale_sat";
        vecs[2].m     = diag(32'h7FFF_0000);
        vecs[2].t     = mkt(mkv(32'h0004_0000, 32'h0, 32'h0, 32'h0),
                            mkv(32'hFFFC_0000, 32'h0, 32'h0, 32'h0), z4);
        vecs[2].last  = 1'b0;
        vecs[2].exp_t = mkt(mkv(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0),
                            mkv(32'h8000_0000, 32'h0, 32'h0, 32'h0), z4);
        vecs[2].exp_sat = 1'b1;

        mt = '0;
        mt[3][2] = FX_ONE;
        mt[2][3] = FX_ONE;
        mt[1][1] = FX_ONE;
        mt[0][0] = FX_ONE;
        vecs[3].name  = "swap_xy";
        vecs[3].m     = mt;
        vecs[3].t     = mkt(mkv(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, FX_ONE),
                            mkv(32'h0, 32'h0005_0000, 32'h0, FX_ONE),
                            mkv(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000));
        vecs[3].last  = 1'b0;
        vecs[3].exp_t = mkt(mkv(32'hFFFF_0000, 32'h0002_0000, 32'h0000_8000, FX_ONE),
                            mkv(32'h0005_0000, 32'h0, 32'h0, FX_ONE),
                            mkv(32'h0002_0000, 32'h0001_0000, 32'h0003_0000, 32'h0004_0000));
        vecs[3].exp_sat = 1'b0;

        vecs[4].name  = "half_floor";
        vecs[4].m     = diag(32'h0000_8000);
        vecs[4].t     = mkt(mkv(32'hFFFF_FFFF, 32'h0000_0003, 32'h0003_0000, 32'hFFFD_0000),
                            z4, mkv(32'h0001_0000, 32'h0, 32'h0, 32'h0));
        vecs[4].last  = 1'b1;
        vecs[4].exp_t = mkt(mkv(32'hFFFF_FFFF, 32'h0000_0001, 32'h0001_8000, 32'hFFFE_8000),
                            z4, mkv(32'h0000_8000, 32'h0, 32'h0, 32'h0));
        vecs[4].exp_sat = 1'b0;

        mt = diag(FX_ONE);
        mt[3][2] = FX_ONE;
        mt[3][1] = FX_ONE;
        mt[3][0] = FX_ONE;
        vecs[5].name  = "row_sum";
        vecs[5].m     = mt;
        vecs[5].t     = mkt(mkv(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000),
                            mkv(32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000), z4);
        vecs[5].last  = 1'b0;
        vecs[5].exp_t = mkt(mkv(32'h000A_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000),
                            mkv(32'hFFFC_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000), z4);
        vecs[5].exp_sat = 1'b0;

        rst_in   = 1'b1;
        valid_in = 1'b0;
        last_in  = 1'b0;
        ready_in = 1'b0;
        tri_in   = '0;
        mat_in   = '0;
        repeat (3) tick();
        rst_in = 1'b0;
        check("reset flags", {380'd0, valid_out, ready_out, last_out, sat_out},
              {380'd0, 4'b0100});
        check("reset tri_out", tri_out, '0);

        for (int i = 0; i < 6; i++) begin
            run_tri(vecs[i].name, vecs[i].m, vecs[i].t, vecs[i].last, 0,
                    vecs[i].exp_t, vecs[i].exp_sat);
        end

        // Long downstream stall with valid_in asserted throughout HOLD.
        run_tri("stall20", vecs[0].m, vecs[0].t, 1'b1, 20, vecs[0].exp_t, 1'b0);

        // Twelve back-to-back triangles; only the last carries last_in.
        for (int i = 0; i < 12; i++) begin
            run_tri($sformatf("b2b%0d", i), vecs[1].m,
                    mkt(mkv(32'(i) << 16, 32'h0, 32'h0, FX_ONE), z4, z4), (i == 11), 0,
                    mkt(mkv(32'(i + 5) << 16, 32'h0, 32'h0, FX_ONE), z4, z4), 1'b0);
        end

        // Reset in the middle of MAC abandons the triangle.
        mat_in   = vecs[2].m;
        tri_in   = vecs[2].t;
        last_in  = 1'b1;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        last_in  = 1'b0;
        repeat (20) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("midrst flags", {380'd0, valid_out, ready_out, last_out, sat_out},
              {380'd0, 4'b0100});
        check("midrst tri_out", tri_out, '0);
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (valid_out) seen++;
        end
        check("midrst no valid", 384'(seen), 384'(0));
        run_tri("after_rst", vecs[1].m, vecs[1].t, 1'b0, 0, vecs[1].exp_t, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tri_transform.md
TRI_TRANSFORM -- requirements
Module: tri_transform

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16, meaning fraction bits of signed fixed-point words (Q16.16).
REQ-002 SHALL have port clk_in  input  1  system clock; one clock, all logic on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port tri_in  input  32x[2:0][3:0]  triangle from vertex fetch; [v][3]=x, [2]=y, [1]=z, [0]=w, signed fixed-point.
REQ-005 SHALL have port last_in  input  1  tags tri_in as final facet of object.
REQ-006 SHALL have port valid_in  input  1  tri_in/last_in valid.
REQ-007 SHALL have port ready_out  output  1  block can accept a triangle.
REQ-008 SHALL have port mat_in  input  32x[3:0][3:0]  transform matrix; [k][j] = row k, column j, same component indexing as tri_in.
REQ-009 SHALL have port tri_out  output  32x[2:0][3:0]  transformed triangle, same layout as tri_in.
REQ-010 SHALL have port last_out  output  1  registered copy of accepted last_in.
REQ-011 SHALL have port valid_out  output  1  tri_out valid.
REQ-012 SHALL have port ready_in  input  1  downstream accepts tri_out.
REQ-013 SHALL have port sat_out  output  1  at least one tri_out word saturated.

Function
REQ-014 SHALL implement states IDLE, MAC, HOLD.
REQ-015 IDLE: ready_out=1; on valid_in=1, capture tri_in, mat_in, last_in, clear accumulator and sat flag, go to MAC.
REQ-016 SHALL use mat_in only at acceptance; later mat_in changes do not affect the triangle in flight.
REQ-017 MAC: one multiply-accumulate per cycle, order vertex v=0..2, component k=3..0, term j=3..0; 48 cycles total.
REQ-018 SHALL compute tri_out[v][k] = sum over j of mat[k][j]*tri[v][j].
REQ-019 Products SHALL be full 64-bit signed; the accumulator SHALL be 66-bit signed.
REQ-020 Result SHALL be accumulator arithmetically shifted right FRAC_BITS (truncation toward -inf), then saturated to [0x8000_0000, 0x7FFF_FFFF].
REQ-021 Any saturation SHALL set sat_out for that triangle.
REQ-022 After the 48th MAC, go to HOLD with valid_out=1; accept-to-valid_out latency is exactly 49 cycles.
REQ-023 HOLD: tri_out, last_out, sat_out stable while valid_out=1 and ready_in=0.
REQ-024 HOLD with ready_in=1: transfer occurs, valid_out=0 and state IDLE next cycle; no same-cycle new acceptance.
REQ-025 ready_out SHALL be 0 in MAC and HOLD; valid_in ignored there.
REQ-026 valid_out SHALL never be asserted outside HOLD.

Reset
REQ-027 rst_in SHALL force IDLE, ready_out=1 on the following cycle, valid_out=0, last_out=0, sat_out=0, tri_out all zero.
REQ-028 rst_in in MAC or HOLD SHALL abandon the triangle with no output transfer.

Structure
REQ-029 Shared package SHALL hold FRAC_BITS default, typedefs vertex_t (4x32), tri_t (3 x vertex_t), mat_t (4x4x32), constant FX_ONE=32'h0001_0000.
REQ-030 MAC datapath (multiply, accumulate, shift, saturate) SHALL be sub-module fx_mac; FSM and counters in tri_transform.

Verification
REQ-031 Identity mat (FX_ONE diagonal), vertex (0x0002_0000, 0xFFFF_0000, 0x0000_8000, FX_ONE) -> identical tri_out, valid_out exactly 49 cycles after accept, sat_out=0.
REQ-032 Translation mat (identity, column 0 of row 3 = 0x0005_0000), x=0x0001_0000, w=FX_ONE -> x_out=0x0006_0000, others unchanged.
REQ-033 Scale mat 0x7FFF_0000 diagonal, x=0x0004_0000 -> x_out=0x7FFF_FFFF, sat_out=1; x=0xFFFC_0000 -> 0x8000_0000.
REQ-034 ready_in held 0 for 20 cycles in HOLD -> tri_out stable, valid_out=1, ready_out=0; release -> one transfer, ready_out=1 next cycle.
REQ-035 last_in=1 with 12 back-to-back triangles -> last_out=1 only on 12th output; mat_in changed mid-MAC has no effect.
REQ-036 rst_in pulsed at MAC cycle 20 -> valid_out never rises for that triangle, ready_out=1 next cycle, new triangle processes correctly.
